// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one byte-wide, 1-cycle-latency block RAM port between a
// 32-bit word requester (sequenced as four little-endian byte beats) and an
// 8-bit byte requester, with round-robin resolution of simultaneous requests.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  // word requester
  input  logic                  w_req,
  input  logic                  w_we,
  input  logic [ADDR_WIDTH-3:0] w_addr,
  input  logic [31:0]           w_wdata,
  input  logic [3:0]            w_be,
  output logic [31:0]           w_rdata,
  output logic                  w_ack,
  // byte requester
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic [7:0]            b_rdata,
  output logic                  b_ack,
  // RAM port
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [7:0]            mem_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_LAST = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // Select byte lane k of a 32-bit little-endian word.
  function automatic logic [7:0] byte_lane(input logic [31:0] d, input logic [1:0] k);
    logic [7:0] r;
    case (k)
      2'd0:    r = d[7:0];
      2'd1:    r = d[15:8];
      2'd2:    r = d[23:16];
      2'd3:    r = d[31:24];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Return d with byte lane k replaced by b.
  function automatic logic [31:0] put_lane(input logic [31:0] d, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = d;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = d;
    endcase
    return r;
  endfunction

  // Sequencer state
  state_t                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic                  last_byte_q, last_byte_d;   // 1: byte port granted most recently
  // Transaction latched at grant (byte transactions use lane 0 of the data)
  logic                  is_word_q, is_word_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  // Read capture pipeline: remembers which lane the previous cycle read
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            rd_lane_q, rd_lane_d;
  logic [31:0]           rd_buf_q, rd_buf_d;
  // Registered outputs
  logic [31:0]           w_rdata_q, w_rdata_d;
  logic [7:0]            b_rdata_q, b_rdata_d;
  logic                  w_ack_q, w_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_din_q, mem_din_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  mem_ren_q, mem_ren_d;
  logic                  busy_q, busy_d;

  // Beat to be placed on the RAM bus in the next cycle
  logic                  iss_s;
  logic                  iss_word_s;
  logic                  iss_we_s;
  logic [ADDR_WIDTH-1:0] iss_addr_s;
  logic [31:0]           iss_wdata_s;
  logic [3:0]            iss_be_s;
  logic [1:0]            iss_beat_s;
  logic                  iss_en_s;
  logic                  pick_word_s;

  // Next-state, arbitration, beat issue and read-capture logic
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_byte_d = last_byte_q;
    is_word_d   = is_word_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    w_rdata_d   = w_rdata_q;
    b_rdata_d   = b_rdata_q;
    w_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    mem_addr_d  = {ADDR_WIDTH{1'b0}};
    mem_din_d   = 8'h00;
    mem_wen_d   = 1'b0;
    mem_ren_d   = 1'b0;
    iss_s       = 1'b0;
    iss_word_s  = is_word_q;
    iss_we_s    = we_q;
    iss_addr_s  = addr_q;
    iss_wdata_s = wdata_q;
    iss_be_s    = be_q;
    iss_beat_s  = beat_q;
    iss_en_s    = 1'b0;
    pick_word_s = 1'b0;

    // The previous cycle's RAM read lands on mem_dout now
    rd_pend_d = mem_ren_q;
    rd_lane_d = beat_q;
    if (rd_pend_q) begin
      rd_buf_d = put_lane(rd_buf_q, rd_lane_q, mem_dout);
    end else begin
      rd_buf_d = rd_buf_q;
    end

    case (state_q)
      S_IDLE: begin
        if (w_req || b_req) begin
          // On a tie the port that did not win last time goes first
          if (w_req && b_req) begin
            pick_word_s = last_byte_q;
          end else begin
            pick_word_s = w_req;
          end
          last_byte_d = ~pick_word_s;
          is_word_d   = pick_word_s;
          beat_d      = 2'd0;
          state_d     = S_BEAT;
          if (pick_word_s) begin
            we_d    = w_we;
            addr_d  = {w_addr, 2'b00};
            wdata_d = w_wdata;
            be_d    = w_be;
          end else begin
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = {24'h000000, b_wdata};
            be_d    = 4'b0001;
          end
          iss_s       = 1'b1;
          iss_word_s  = is_word_d;
          iss_we_s    = we_d;
          iss_addr_s  = addr_d;
          iss_wdata_s = wdata_d;
          iss_be_s    = be_d;
          iss_beat_s  = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BEAT: begin
        if (is_word_q && (beat_q != 2'd3)) begin
          beat_d     = beat_q + 2'd1;
          iss_s      = 1'b1;
          iss_beat_s = beat_d;
        end else begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        // Final read byte is on mem_dout now; publish the assembled result
        if (!we_q) begin
          if (is_word_q) begin
            w_rdata_d = rd_buf_d;
          end else begin
            b_rdata_d = mem_dout;
          end
        end else begin
          w_rdata_d = w_rdata_q;
        end
        w_ack_d = is_word_q;
        b_ack_d = ~is_word_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Drive the RAM bus for the issued beat; an idle bus carries zeros
    if (iss_s) begin
      if (iss_word_s) begin
        mem_addr_d = {iss_addr_s[ADDR_WIDTH-1:2], iss_beat_s};
        mem_din_d  = byte_lane(iss_wdata_s, iss_beat_s);
        iss_en_s   = iss_be_s[iss_beat_s];
      end else begin
        mem_addr_d = iss_addr_s;
        mem_din_d  = iss_wdata_s[7:0];
        iss_en_s   = 1'b1;
      end
      if (iss_we_s) begin
        mem_wen_d = iss_en_s;
        mem_ren_d = 1'b0;
      end else begin
        mem_wen_d = 1'b0;
        mem_ren_d = 1'b1;
      end
      if (!(mem_wen_d || mem_ren_d)) begin
        mem_addr_d = {ADDR_WIDTH{1'b0}};
        mem_din_d  = 8'h00;
      end else begin
        mem_din_d  = mem_din_d;
      end
    end else begin
      mem_addr_d = {ADDR_WIDTH{1'b0}};
      mem_din_d  = 8'h00;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= 2'd0;
      last_byte_q <= 1'b1;
      is_word_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= 32'h00000000;
      be_q        <= 4'b0000;
      rd_pend_q   <= 1'b0;
      rd_lane_q   <= 2'd0;
      rd_buf_q    <= 32'h00000000;
      w_rdata_q   <= 32'h00000000;
      b_rdata_q   <= 8'h00;
      w_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_din_q   <= 8'h00;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_byte_q <= last_byte_d;
      is_word_q   <= is_word_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_pend_q   <= rd_pend_d;
      rd_lane_q   <= rd_lane_d;
      rd_buf_q    <= rd_buf_d;
      w_rdata_q   <= w_rdata_d;
      b_rdata_q   <= b_rdata_d;
      w_ack_q     <= w_ack_d;
      b_ack_q     <= b_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
      busy_q      <= busy_d;
    end
  end

  assign w_rdata  = w_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign w_ack    = w_ack_q;
  assign b_ack    = b_ack_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_wen  = mem_wen_q;
  assign mem_ren  = mem_ren_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 1-cycle block RAM.
module tb_bram_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_req, w_we;
  logic [AW-3:0] w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [31:0]   w_rdata;
  logic          w_ack;
  logic          b_req, b_we;
  logic [AW-1:0] b_addr;
  logic [7:0]    b_wdata;
  logic [7:0]    b_rdata;
  logic          b_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_wen, mem_ren;
  logic [7:0]    mem_dout;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle log of one run (index = cycles after the grant cycle T)
  logic [AW-1:0] lg_addr [0:31];
  logic [7:0]    lg_din  [0:31];
  logic [31:0]   lg_wrd  [0:31];
  logic [7:0]    lg_brd  [0:31];
  logic [31:0]   wen_vec, ren_vec, wack_vec, back_vec, busy_vec;

  logic [7:0] ram [0:(1<<AW)-1];

  bram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .w_req(w_req), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata), .w_be(w_be),
    .w_rdata(w_rdata), .w_ack(w_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
  end

  // Byte-wide RAM: write and registered read on the rising edge
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_din;
    if (mem_ren) mem_dout <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Raise the requests in cycle T, log cycles T+1..T+ncyc, drop both at T+drop_at
  task automatic run(input logic wq, input logic bq, input int ncyc, input int drop_at);
    wen_vec = 32'h0; ren_vec = 32'h0; wack_vec = 32'h0; back_vec = 32'h0; busy_vec = 32'h0;
    w_req = wq;
    b_req = bq;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      lg_addr[k]  = mem_addr;
      lg_din[k]   = mem_din;
      lg_wrd[k]   = w_rdata;
      lg_brd[k]   = b_rdata;
      wen_vec[k]  = mem_wen;
      ren_vec[k]  = mem_ren;
      wack_vec[k] = w_ack;
      back_vec[k] = b_ack;
      busy_vec[k] = busy;
      if (k == drop_at) begin
        w_req = 1'b0;
        b_req = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrdata"}, w_rdata, 32'h0);
    check({tag, "_brdata"}, {24'h0, b_rdata}, 32'h0);
    check({tag, "_addr"}, {22'h0, mem_addr}, 32'h0);
    check({tag, "_din"}, {24'h0, mem_din}, 32'h0);
    check({tag, "_ctl"}, {27'h0, w_ack, b_ack, mem_wen, mem_ren, busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    w_req = 1'b0; w_we = 1'b0; w_addr = '0; w_wdata = 32'h0; w_be = 4'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = 8'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Word write 0xA1B2C3D4 to word 3, one-cycle request pulse
    w_we = 1'b1; w_addr = 8'd3; w_wdata = 32'hA1B2C3D4; w_be = 4'hF;
    run(1'b1, 1'b0, 8, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_addr%0d", k), {22'h0, lg_addr[k+1]}, 32'd12 + k);
    end
    check("wr_din", {lg_din[1], lg_din[2], lg_din[3], lg_din[4]}, 32'hD4C3B2A1);
    check("wr_wen", wen_vec, 32'h0000001E);
    check("wr_ren", ren_vec, 32'h0);
    check("wr_ack", wack_vec, 32'h00000040);
    check("wr_busy", busy_vec, 32'h0000007E);

    // Word read-back; w_rdata must not change before the ack cycle
    w_we = 1'b0;
    run(1'b1, 1'b0, 8, 1);
    check("rd_ren", ren_vec, 32'h0000001E);
    check("rd_hold", lg_wrd[5], 32'h0);
    check("rd_data", lg_wrd[6], 32'hA1B2C3D4);
    check("rd_ack", wack_vec, 32'h00000040);

    // Byte read of address 13
    b_we = 1'b0; b_addr = 10'd13;
    run(1'b0, 1'b1, 5, 1);
    check("brd_addr", {22'h0, lg_addr[1]}, 32'd13);
    check("brd_data", {24'h0, lg_brd[3]}, 32'h000000C3);
    check("brd_ack", back_vec, 32'h00000008);
    check("brd_busy", busy_vec, 32'h0000000E);

    // Masked word write: only lanes 0 and 2 touched
    w_we = 1'b1; w_wdata = 32'hFFFFFFFF; w_be = 4'b0101;
    run(1'b1, 1'b0, 8, 1);
    check("mwr_wen", wen_vec, 32'h0000000A);
    check("mwr_idle_bus", {lg_addr[2], lg_din[2]}, 32'h0);
    check("mwr_addr2", {22'h0, lg_addr[3]}, 32'd14);
    check("mwr_ack", wack_vec, 32'h00000040);
    w_we = 1'b0;
    run(1'b1, 1'b0, 8, 1);
    check("mrd_data", lg_wrd[6], 32'hA1FFC3FF);

    // Byte write then byte read at address 40
    b_we = 1'b1; b_addr = 10'd40; b_wdata = 8'h5A;
    run(1'b0, 1'b1, 5, 1);
    check("bwr_wen", wen_vec, 32'h00000002);
    check("bwr_din", {24'h0, lg_din[1]}, 32'h0000005A);
    b_we = 1'b0;
    run(1'b0, 1'b1, 5, 1);
    check("brd2_data", {24'h0, lg_brd[3]}, 32'h0000005A);

    // Simultaneous requests right after reset: word, byte, word
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w_we = 1'b0; w_addr = 8'd3; b_we = 1'b0; b_addr = 10'd12;
    run(1'b1, 1'b1, 17, 17);
    check("rr_wack", wack_vec, 32'h00020040);
    check("rr_back", back_vec, 32'h00000400);
    check("rr_byte_beat", {22'h0, lg_addr[8]}, 32'd12);
    check("rr_wdata", lg_wrd[6], 32'hA1FFC3FF);
    check("rr_bdata", {24'h0, lg_brd[10]}, 32'h000000FF);
    repeat (3) @(negedge clk);
    check("rr_idle", {31'h0, busy}, 32'h0);

    // Reset in the middle of a word write: two bytes land, no ack
    w_we = 1'b1; w_addr = 8'd5; w_wdata = 32'h11223344; w_be = 4'hF;
    run(1'b1, 1'b0, 2, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    check("midrst_noack", wack_vec, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    w_we = 1'b0;
    run(1'b1, 1'b0, 8, 1);
    check("midrst_rd", lg_wrd[6], 32'h00003344);
    check("midrst_ack", wack_vec, 32'h00000040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
